// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Shares one combinational ALU between two requesters. Requests are
//   round-robin arbitrated and accepted with a valid/ready handshake. The
//   winning operands are held on the ALU for ALU_LAT cycles. The result and
//   carry are then captured and returned to the winner with a valid/ready
//   response handshake. Only one operation is in flight at a time.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   reqK_valid/a/b/sel, reqK_ready request channel of port K (K = 0, 1)
//   rspK_valid/data/carry, rspK_ready response channel of port K
//   alu_a, alu_b, alu_sel          operand/select lines to the shared ALU
//   alu_result, alu_carry          ALU outputs, captured after settling
//   busy                           high whenever an operation is in flight
//   ops_done                       wrapping count of completed responses
module alu_share_ctrl #(
    parameter int WIDTH   = 8,
    parameter int SEL_W   = 4,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             req1_ready,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_carry,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_carry,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    // The counter only ever holds ALU_LAT-1 down to 0.
    localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Per-port views of the request/response channels, indexed by port id.
    logic [1:0]       req_valid_vec;
    logic [1:0]       rsp_ready_vec;
    logic [WIDTH-1:0] req_a_arr   [2];
    logic [WIDTH-1:0] req_b_arr   [2];
    logic [SEL_W-1:0] req_sel_arr [2];
    logic [1:0]       req_ready_vec;
    logic [1:0]       rsp_valid_vec;
    logic [WIDTH-1:0] rsp_data_reg  [2];
    logic             rsp_carry_reg [2];

    logic [WIDTH-1:0] a_reg, b_reg;
    logic [SEL_W-1:0] sel_reg;
    logic             id_reg;
    logic             ptr_reg;
    logic [LAT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] ops_done_reg;

    logic [1:0] grant;
    logic       grant_id;
    logic       accept;
    logic       capture;
    logic       rsp_done;

    assign req_valid_vec  = {req1_valid, req0_valid};
    assign rsp_ready_vec  = {rsp1_ready, rsp0_ready};
    assign req_a_arr[0]   = req0_a;
    assign req_a_arr[1]   = req1_a;
    assign req_b_arr[0]   = req0_b;
    assign req_b_arr[1]   = req1_b;
    assign req_sel_arr[0] = req0_sel;
    assign req_sel_arr[1] = req1_sel;

    // Round robin: the pointer only breaks ties. A lone requester always wins.
    always_comb begin
        grant = req_valid_vec;
        if (req_valid_vec == 2'b11) begin
            grant = ptr_reg ? 2'b10 : 2'b01;
        end
    end

    assign grant_id = grant[1];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        rsp_done   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // ready mirrors the grant in IDLE, so any grant is a handshake
                if (|grant) begin
                    accept     = 1'b1;
                    state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_reg == '0) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_vec[id_reg]) begin
                    rsp_done   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand latch, settle counter, arbitration pointer, completion counter
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg        <= '0;
            b_reg        <= '0;
            sel_reg      <= '0;
            id_reg       <= 1'b0;
            ptr_reg      <= 1'b0;
            cnt_reg      <= '0;
            ops_done_reg <= '0;
        end else begin
            if (accept) begin
                a_reg   <= req_a_arr[grant_id];
                b_reg   <= req_b_arr[grant_id];
                sel_reg <= req_sel_arr[grant_id];
                id_reg  <= grant_id;
                cnt_reg <= LAT_LOAD;
            end else if (state_reg == ST_DRIVE && cnt_reg != '0) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
            if (rsp_done) begin
                ops_done_reg <= ops_done_reg + 1'b1;
                ptr_reg      <= ~id_reg;
            end
        end
    end

    // Per-port response registers and handshake outputs
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        always_ff @(posedge clk) begin
            if (rst) begin
                rsp_data_reg[gi]  <= '0;
                rsp_carry_reg[gi] <= 1'b0;
            end else if (capture && id_reg == 1'(gi)) begin
                rsp_data_reg[gi]  <= alu_result;
                rsp_carry_reg[gi] <= alu_carry;
            end
        end

        assign req_ready_vec[gi] = (state_reg == ST_IDLE) && grant[gi];
        assign rsp_valid_vec[gi] = (state_reg == ST_RESP) && (id_reg == 1'(gi));
    end

    assign req0_ready = req_ready_vec[0];
    assign req1_ready = req_ready_vec[1];
    assign rsp0_valid = rsp_valid_vec[0];
    assign rsp1_valid = rsp_valid_vec[1];
    assign rsp0_data  = rsp_data_reg[0];
    assign rsp1_data  = rsp_data_reg[1];
    assign rsp0_carry = rsp_carry_reg[0];
    assign rsp1_carry = rsp_carry_reg[1];

    // ALU lines carry the latched operation only while it is settling.
    assign alu_a   = (state_reg == ST_DRIVE) ? a_reg   : '0;
    assign alu_b   = (state_reg == ST_DRIVE) ? b_reg   : '0;
    assign alu_sel = (state_reg == ST_DRIVE) ? sel_reg : '0;

    assign busy     = (state_reg != ST_IDLE);
    assign ops_done = ops_done_reg;

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Controller that shares one combinational 8-bit ALU (operands A/B, 4-bit select, result plus carry) between two requesters.
- Requests are round-robin arbitrated and accepted over a valid/ready handshake.
- The block drives the ALU operand and select lines, waits a programmable settle time, captures result and carry, and returns them to the winning requester over a valid/ready response handshake.
- Sits between the ALU and its clients; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width.
- SEL_W, 4, ALU select width.
- ALU_LAT, 1, cycles the ALU inputs are held before capture (legal values ≥1).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request valid
- req0_a, req0_b  in  WIDTH  port 0 operands
- req0_sel  in  SEL_W  port 0 ALU select
- req0_ready  out  1  port 0 request accepted when valid&ready
- req1_valid, req1_a, req1_b, req1_sel, req1_ready  as port 0, for port 1
- rsp0_valid  out  1  port 0 result valid
- rsp0_data  out  WIDTH  port 0 result
- rsp0_carry  out  1  port 0 carry
- rsp0_ready  in  1  port 0 consumes response
- rsp1_valid, rsp1_data, rsp1_carry, rsp1_ready  as port 0, for port 1
- alu_a, alu_b  out  WIDTH  to ALU operands
- alu_sel  out  SEL_W  to ALU select
- alu_result  in  WIDTH  from ALU
- alu_carry  in  1  from ALU
- busy  out  1  high in any state other than IDLE
- ops_done  out  CNT_W  count of completed responses, wraps

Behaviour:
- Reset (sync, rst high at edge):
  - state=IDLE, priority pointer=port 0, ops_done=0.
  - All req_ready/rsp_valid=0; rsp data/carry=0; alu_a/alu_b/alu_sel=0; busy=0.
  - A reset in any state aborts the in-flight operation: no response is issued and the result is lost.
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - req_ready is combinational: reqK_ready=1 only for the granted port, and only while in IDLE.
  - Grant: if both valid, the port named by the pointer wins; if exactly one is valid, that port wins regardless of the pointer; if none is valid, no grant.
  - On valid&ready, latch a/b/sel and the granted id, load the latency counter with ALU_LAT-1, and go to DRIVE.
- DRIVE:
  - alu_a/alu_b/alu_sel are driven from the latched registers and held stable for ALU_LAT cycles.
  - When the counter reaches 0, capture alu_result/alu_carry into rspK_data/rspK_carry and go to RESP.
  - In IDLE the ALU inputs return to 0.
- RESP:
  - rspK_valid=1 for the granted port only. Data and carry are held stable until rspK_ready=1.
  - On the handshake edge: rsp_valid falls, ops_done increments (wrapping from all-ones to 0), pointer = the other port, go to IDLE.
  - No new request is accepted in the cycle of the response handshake. Minimum issue interval is ALU_LAT+2 cycles.
- Latency: accept at edge E. rsp_valid is high in the cycle starting at E+ALU_LAT clock periods after that edge (ALU_LAT=1: response visible 1 cycle after accept, i.e. 2 edges from request presentation).
- Requester rules:
  - Requesters must hold valid and payload stable until ready. A dropped valid before accept is legal and simply yields no grant.
  - The non-granted port sees ready=0 and waits; starvation is bounded to one operation.
- busy=1 in DRIVE and RESP.
- Arithmetic: carry and result come from the ALU only. The block does no arithmetic beyond the latency counter and ops_done.

Test Plan (bench ALU stub: sel 0 = A+B with carry, sel 1 = A−B):
- After reset, port 0 presents A=05, B=04, sel=0, ALU_LAT=1 → req0_ready same cycle; alu_a=05, alu_b=04 for 1 cycle; rsp0_valid with data=09, carry=0; ops_done=1 after rsp0_ready.
- Port 1 presents A=FF, B=01, sel=0 → rsp1_data=00, rsp1_carry=1; rsp0_valid stays 0 throughout.
- Both ports valid in the same cycle after reset (p0: 10+20, p1: 30−10) → port 0 served first (data 30), then port 1 (data 20); ops_done=2.
- Both ports continuously valid for 6 operations with rsp_ready tied high → grants alternate 0,1,0,1,0,1; issue interval exactly ALU_LAT+2 cycles.
- rsp0_ready held low 5 cycles → rsp0_valid/data/carry stable; req1_ready stays 0; busy=1; port 1 is served only after the handshake.
- rst asserted during DRIVE with ALU_LAT=3 → at the next edge: busy=0, all valid/ready=0, alu_*=0, ops_done=0; the first request after reset is granted to port 0.
